// File: rtl/switch_debounce8.sv
// Switch input conditioner: per-line two-flop synchroniser plus counter debounce,
// presenting clean x/en levels and a one-cycle changed strobe to the encoder.
`timescale 1ns/1ps

module switch_debounce8 #(
    parameter int N             = 8,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_raw,
    input  logic         en_raw,
    output logic [N-1:0] x,
    output logic         en,
    output logic         changed
);

    localparam int L = N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } lane_state_t;

    logic [L-1:0]     raw_s;
    logic [L-1:0]     s1_r;
    logic [L-1:0]     s2_r;
    logic [L-1:0]     d_r;
    logic [L-1:0]     flip_s;
    logic [L-1:0]     d_next_s;
    logic [CNT_W-1:0] c_r  [L];
    lane_state_t      st_r [L];
    logic             changed_r;

    // The enable switch rides along as the topmost lane.
    assign raw_s = {en_raw, sw_raw};

    // Flip decision: a lane flips when its mismatch run reaches the full count.
    always_comb begin
        flip_s   = {L{1'b0}};
        d_next_s = d_r;
        for (int i = 0; i < L; i++) begin
            if ((st_r[i] == ST_COUNTING) && (c_r[i] == LAST_CNT)) begin
                flip_s[i]   = 1'b1;
                d_next_s[i] = s2_r[i];
            end else begin
                flip_s[i]   = 1'b0;
                d_next_s[i] = d_r[i];
            end
        end
    end

    // Lane state, synchronisers, counters and the merged change strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r      <= {L{1'b0}};
            s2_r      <= {L{1'b0}};
            d_r       <= {L{1'b0}};
            changed_r <= 1'b0;
            for (int i = 0; i < L; i++) begin
                c_r[i]  <= CNT_ZERO;
                st_r[i] <= ST_STABLE;
            end
        end else begin
            s1_r      <= raw_s;
            s2_r      <= s1_r;
            d_r       <= d_next_s;
            changed_r <= |flip_s;
            for (int i = 0; i < L; i++) begin
                case (st_r[i])
                    ST_STABLE:   c_r[i] <= CNT_ZERO;
                    ST_COUNTING: c_r[i] <= flip_s[i] ? CNT_ZERO : (c_r[i] + CNT_ONE);
                    default:     c_r[i] <= CNT_ZERO;
                endcase
                // State tracks whether the next cycle's s2 disagrees with the next d.
                st_r[i] <= (s1_r[i] != d_next_s[i]) ? ST_COUNTING : ST_STABLE;
            end
        end
    end

    assign x       = d_r[N-1:0];
    assign en      = d_r[N];
    assign changed = changed_r;

endmodule

// File: tb/tb_switch_debounce8.sv
// Cycle-by-cycle vector bench for switch_debounce8 with STABLE_CYCLES=4, CNT_W=3.
`timescale 1ns/1ps

module tb_switch_debounce8;

    logic       clk;
    logic       rst;
    logic [7:0] sw_raw;
    logic       en_raw;
    logic [7:0] x;
    logic       en;
    logic       changed;

    int total;
    int bad;

    typedef struct packed {
        logic       rst;
        logic [7:0] sw;
        logic       en_in;
        logic [7:0] ex_x;
        logic       ex_en;
        logic       ex_ch;
    } vec_t;

    typedef struct packed {
        logic [7:0] x;
        logic       en;
        logic       ch;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    switch_debounce8 #(
        .N(8),
        .STABLE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .en_raw(en_raw),
        .x(x),
        .en(en),
        .changed(changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic add(input int n, input logic r, input logic [7:0] s, input logic e,
                       input logic [7:0] ex, input logic een, input logic ech);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{r, s, e, ex, een, ech});
        end
    endtask

    task automatic check_out(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty vec=%0d", idx);
        end else begin
            e = sb.pop_front();
            total++;
            if (x !== e.x) begin
                bad++;
                $display("FAIL x vec=%0d got=%h want=%h", idx, x, e.x);
            end
            total++;
            if (en !== e.en) begin
                bad++;
                $display("FAIL en vec=%0d got=%b want=%b", idx, en, e.en);
            end
            total++;
            if (changed !== e.ch) begin
                bad++;
                $display("FAIL changed vec=%0d got=%b want=%b", idx, changed, e.ch);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        sw_raw = 8'h00;
        en_raw = 1'b0;

        // Reset with switches high, then qualification after release.
        add(2, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
        add(5, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
        add(2, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        // Clean press of bit 2.
        add(2, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add(5, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1);
        add(3, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
        // Three-cycle glitch on bit 3 is rejected.
        add(3, 1'b0, 8'h0C, 1'b0, 8'h04, 1'b0, 1'b0);
        add(5, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
        // Four-cycle pulse on bit 3 gets through, and its release too.
        add(4, 1'b0, 8'h0C, 1'b0, 8'h04, 1'b0, 1'b0);
        add(1, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
        add(1, 1'b0, 8'h04, 1'b0, 8'h0C, 1'b0, 1'b1);
        add(3, 1'b0, 8'h04, 1'b0, 8'h0C, 1'b0, 1'b0);
        add(1, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1);
        add(1, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
        // Bounce on bit 7, then steady high.
        add(2, 1'b0, 8'h84, 1'b0, 8'h04, 1'b0, 1'b0);
        add(2, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
        add(2, 1'b0, 8'h84, 1'b0, 8'h04, 1'b0, 1'b0);
        add(2, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
        add(5, 1'b0, 8'h84, 1'b0, 8'h04, 1'b0, 1'b0);
        add(1, 1'b0, 8'h84, 1'b0, 8'h84, 1'b0, 1'b1);
        add(1, 1'b0, 8'h84, 1'b0, 8'h84, 1'b0, 1'b0);
        // Simultaneous lanes including enable.
        add(2, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add(5, 1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1, 1'b0, 8'h81, 1'b1, 8'h81, 1'b1, 1'b1);
        add(2, 1'b0, 8'h81, 1'b1, 8'h81, 1'b1, 1'b0);
        // Reset while lane 2 is mid-count restarts qualification.
        add(2, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add(4, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
        add(5, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1);
        add(2, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            rst    = vecs[v].rst;
            sw_raw = vecs[v].sw;
            en_raw = vecs[v].en_in;
            sb.push_back('{vecs[v].ex_x, vecs[v].ex_en, vecs[v].ex_ch});
            @(posedge clk);
            #1;
            check_out(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_debounce8.md
# switch_debounce8

Input-conditioning stage that sits directly upstream of the 8-to-3 priority encoder on the experiment board. It synchronises eight raw slide-switch inputs plus a raw enable switch into the `clk` domain. It then debounces each line independently and presents clean, glitch-free `x[7:0]` and `en` to the encoder, with a one-cycle `changed` strobe whenever any debounced line updates.

## Interface
- `N`, 8, number of data switch lines.
- `STABLE_CYCLES`, 1000000, consecutive cycles a synchronised input must differ from its debounced value before the debounced value flips (20 ms at 50 MHz). Legal range is 1 to 2^`CNT_W`.
- `CNT_W`, 20, width of each per-line stability counter. Must hold `STABLE_CYCLES`-1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sw_raw` input N: raw asynchronous switch levels.
- `en_raw` input 1: raw asynchronous enable switch level.
- `x` output N: debounced switch levels; feeds the encoder's `x`.
- `en` output 1: debounced enable; feeds the encoder's `en`.
- `changed` output 1: one-cycle pulse when any bit of `x` or `en` updates.

## Operation
- N+1 identical lanes: lane i for i<N handles `sw_raw[i]`, and lane N handles `en_raw`. Lanes never interact except through the OR that forms `changed`.
- Each lane has:
  - a two-flop synchroniser (`s1`, `s2`);
  - a debounced register `d`, which drives `x[i]` or `en`;
  - a counter `c` of width `CNT_W`.
- Per-lane update on each edge when `rst`=0:
  - `s1` <= raw; `s2` <= `s1`.
  - If `s2` == `d`: `c` <= 0. Any agreeing cycle fully restarts the count; there is no partial credit.
  - If `s2` != `d` and `c` < `STABLE_CYCLES`-1: `c` <= `c`+1.
  - If `s2` != `d` and `c` == `STABLE_CYCLES`-1: `d` <= `s2` and `c` <= 0.
- Each lane behaves as a two-state machine:
  - STABLE: `c`=0, `s2`==`d`.
  - COUNTING: `s2`!=`d`.
  - STABLE→COUNTING on the first mismatch.
  - COUNTING→STABLE on either a mismatch disappearing (no flip) or the count completing (flip).
- `changed` is a registered signal. It is 1 on the cycle after an edge at which at least one lane flipped `d`, and coincides with the new `x`/`en` value. Otherwise it is 0.
- Multiple lanes flipping on the same edge produce a single one-cycle `changed` pulse.
- Reset, at any time including mid-count: every `s1`, `s2`, `d`, `c` and `changed` is cleared to 0 at the edge where `rst`=1.
  - After reset: `x`=0, `en`=0, `changed`=0.
  - A switch held high through reset re-qualifies from zero count after `rst` falls.
- No arithmetic overflow is possible: `c` never exceeds `STABLE_CYCLES`-1.
- `STABLE_CYCLES`=1 degenerates to synchroniser only: `d` follows `s2` one edge later.

## Timing
- Reset values: `x`=0, `en`=0, `changed`=0.
- Latency, for a raw level first sampled by `s1` at edge k and held stable:
  - `s2` holds it after edge k+1.
  - First mismatch count at edge k+2.
  - `d` flips at edge k+1+`STABLE_CYCLES`.
  - `changed`=1 for exactly the cycle following that edge.
- Total latency from the first sampling edge to the output change is `STABLE_CYCLES`+1 edges.
- Rejection: any raw pulse or glitch whose synchronised duration is shorter than `STABLE_CYCLES` consecutive mismatching cycles never reaches `x`/`en`.
- A bounce that returns to the old level resets `c`. A bounce that toggles past the old level continues counting, because the mismatch persists.
- No handshake is used: downstream consumes `x`/`en` combinationally every cycle.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `CNT_W`=3.

1. Reset: hold `rst`=1 for 2 cycles with `sw_raw`=8'hFF, `en_raw`=1. Required: `x`=0, `en`=0, `changed`=0 throughout reset. After `rst` falls, `x`=8'hFF and `en`=1 appear exactly 5 edges after the first post-reset edge, with `changed`=1 for exactly one cycle.
2. Clean press: from all-zero, set `sw_raw`=8'h04 before edge k. Required: `x`=8'h04 after edge k+5, `changed` pulses once, and `x` stays 8'h04.
3. Glitch rejection: drive `sw_raw[3]` high for 3 clock cycles, then low. Required: `x` stays 8'h00 and `changed` never asserts. Repeat with 4 cycles high: `x[3]` rises.
4. Bounce: toggle `sw_raw[7]` 1/0/1/0 every 2 cycles, then hold 1. Required: `x[7]` rises exactly `STABLE_CYCLES`+1 edges after the final rising sample.
5. Simultaneous lanes: change `sw_raw` 8'h00→8'h81 and `en_raw` 0→1 on the same edge. Required: `x`=8'h81 and `en`=1 update on the same edge, with a single one-cycle `changed` pulse.
6. Reset mid-count: assert `rst` for one cycle while lane 2 has `c`=2. Required: `x`=0 and counter cleared. If the input is held, the flip occurs a full 5 edges after `rst` deasserts, not earlier.
